// File: rtl/ir_queue_if.sv
// rtl/ir_queue_if.sv - request and decode signal bundle for the instruction queue
interface ir_queue_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 3
);
  logic             push;
  logic [31:0]      instr_in;
  logic [PC_W-1:0]  pc_in;
  logic             pop;
  logic             flush;
  logic             full;
  logic             valid;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [5:0]       opcode;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [5:0]       funct;
  logic [15:0]      imm;
  logic [31:0]      imm_sext;
  logic [25:0]      IMM;
  logic [PC_W-1:0]  pc_out;

  modport master (
    output push, instr_in, pc_in, pop, flush,
    input  full, valid, count, overflow, opcode, rs, rt, rd, shamt, funct,
           imm, imm_sext, IMM, pc_out
  );

  modport slave (
    input  push, instr_in, pc_in, pop, flush,
    output full, valid, count, overflow, opcode, rs, rt, rd, shamt, funct,
           imm, imm_sext, IMM, pc_out
  );
endinterface

// File: rtl/ir_queue.sv
// rtl/ir_queue.sv - DEPTH-entry instruction/PC queue with field decode at the head
module ir_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input logic       clk,
  input logic       rst,
  ir_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]      instr_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem    [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             is_full;
  logic             is_valid;
  logic             do_pop;
  logic             do_push;
  logic             drop;
  logic [31:0]      head;

  assign is_full  = (cnt == CNT_W'(DEPTH));
  assign is_valid = (cnt != '0);

  // A pop on an empty queue never frees a slot, so there is no bypass path.
  assign do_pop  = q.pop  && !q.flush && is_valid;
  assign do_push = q.push && !q.flush && (!is_full || do_pop);
  assign drop    = q.push && !q.flush && is_full && !do_pop;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
      else if (do_pop && !do_push) cnt <= cnt - CNT_W'(1);
      if (drop) ovf <= 1'b1;
    end
  end

  // Storage carries no reset; valid gating hides stale contents.
  always_ff @(negedge clk) begin
    if (do_push) begin
      instr_mem[wr_ptr] <= q.instr_in;
      pc_mem[wr_ptr]    <= q.pc_in;
    end
  end

  assign head = is_valid ? instr_mem[rd_ptr] : '0;

  assign q.full     = is_full;
  assign q.valid    = is_valid;
  assign q.count    = cnt;
  assign q.overflow = ovf;
  assign q.opcode   = head[31:26];
  assign q.rs       = head[25:21];
  assign q.rt       = head[20:16];
  assign q.rd       = head[15:11];
  assign q.shamt    = head[10:6];
  assign q.funct    = head[5:0];
  assign q.imm      = head[15:0];
  assign q.imm_sext = {{16{head[15]}}, head[15:0]};
  assign q.IMM      = head[25:0];
  assign q.pc_out   = is_valid ? pc_mem[rd_ptr] : '0;
endmodule

// File: tb/tb_ir_queue.sv
// tb/tb_ir_queue.sv - scoreboard bench for ir_queue with directed vectors
module tb_ir_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;

  ir_queue_if #(.PC_W(32), .CNT_W(3)) bus ();

  ir_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic [2:0]  count;
    logic        full;
    logic        ovf;
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  event sample_now;

  function automatic logic [31:0] wd(input logic [31:0] pc);
    return {8'hA5, pc[7:0], ~pc[15:0]};
  endfunction

  task automatic expect_state(input string name, input int cnt, input logic ovf,
                              input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    e.name  = name;
    e.valid = (cnt != 0);
    e.count = 3'(cnt);
    e.full  = (cnt == 4);
    e.ovf   = ovf;
    e.word  = w;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  task automatic step(input logic p, input logic o, input logic f,
                      input logic [31:0] instr, input logic [31:0] pc);
    @(posedge clk);
    #1;
    bus.push     = p;
    bus.pop      = o;
    bus.flush    = f;
    bus.instr_in = instr;
    bus.pc_in    = pc;
    @(negedge clk);
    #1;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.flush = 1'b0;
  endtask

  // Decode fields are checked as the three MIPS formats reassembled from the head.
  always begin
    @(posedge clk or sample_now);
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] rtype, itype, jtype, sext_req;
      e        = sb.pop_front();
      rtype    = {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
      itype    = {bus.opcode, bus.rs, bus.rt, bus.imm};
      jtype    = {bus.opcode, bus.IMM};
      sext_req = {{16{e.word[15]}}, e.word[15:0]};
      checks++;
      if (bus.valid !== e.valid || bus.count !== e.count || bus.full !== e.full ||
          bus.overflow !== e.ovf || bus.pc_out !== e.pc || rtype !== e.word ||
          itype !== e.word || jtype !== e.word || bus.imm_sext !== sext_req) begin
        errors++;
        $display("FAIL %s: got v=%0b cnt=%0d full=%0b ovf=%0b pc=%h r=%h i=%h j=%h sext=%h; want v=%0b cnt=%0d full=%0b ovf=%0b pc=%h word=%h sext=%h",
                 e.name, bus.valid, bus.count, bus.full, bus.overflow, bus.pc_out,
                 rtype, itype, jtype, bus.imm_sext, e.valid, e.count, e.full, e.ovf,
                 e.pc, e.word, sext_req);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] w1, w2, w3, w4;
    w1 = {6'h23, 5'd1, 5'd2, 16'h0004};
    w2 = {6'h08, 5'd2, 5'd1, 16'hFFFF};
    w3 = {6'h02, 26'h0100040};
    w4 = {6'h00, 5'd2, 5'd3, 5'd1, 5'd0, 6'h20};

    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0;
    bus.instr_in = '0; bus.pc_in = '0;
    #2;
    expect_state("reset", 0, 0, 0, 0);
    -> sample_now;
    @(posedge clk); #1 rst = 1'b0;

    step(1, 0, 0, 32'h8C220004, 32'h100); expect_state("lw_head", 1, 0, w1, 32'h100);
    step(1, 1, 0, 32'h2041FFFF, 32'h104); expect_state("addi_neg", 1, 0, w2, 32'h104);
    step(1, 1, 0, 32'h08100040, 32'h108); expect_state("jump", 1, 0, w3, 32'h108);
    step(1, 1, 0, 32'h00430820, 32'h10C); expect_state("rtype", 1, 0, w4, 32'h10C);
    step(0, 1, 0, 0, 0);                   expect_state("drain", 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);                   expect_state("pop_empty", 0, 0, 0, 0);

    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, wd(k * 4), k * 4);
      expect_state("fill_a", k + 1, 0, wd(0), 0);
    end
    step(1, 0, 0, 32'hDEADBEEF, 32'h999);  expect_state("drop", 4, 1, wd(0), 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 0, 0);
      if (k < 3) expect_state("pop_seq", 3 - k, 1, wd(4 * k + 4), 4 * k + 4);
      else       expect_state("pop_last", 0, 1, 0, 0);
    end

    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, wd(16 + k * 4), 16 + k * 4);
      expect_state("fill_b", k + 1, 1, wd(16), 16);
    end
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 0, wd(32 + k * 4), 32 + k * 4);
      expect_state("full_pp", 4, 1, wd(20 + k * 4), 20 + k * 4);
    end
    step(0, 1, 0, 0, 0);                   expect_state("to_three", 3, 1, wd(44), 44);
    step(1, 0, 1, wd(32'h300), 32'h300);   expect_state("flush_push", 0, 0, 0, 0);
    step(1, 0, 0, wd(32'h304), 32'h304);   expect_state("after_flush", 1, 0, wd(32'h304), 32'h304);
    step(0, 1, 0, 0, 0);                   expect_state("empty_again", 0, 0, 0, 0);
    step(1, 1, 0, wd(32'h200), 32'h200);   expect_state("empty_pp", 1, 0, wd(32'h200), 32'h200);
    step(1, 0, 0, wd(32'h204), 32'h204);   expect_state("two", 2, 0, wd(32'h200), 32'h200);

    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    expect_state("async_rst", 0, 0, 0, 0);
    -> sample_now;
    @(posedge clk); #1 rst = 1'b0;
    step(1, 0, 0, wd(32'h208), 32'h208);   expect_state("post_rst", 1, 0, wd(32'h208), 32'h208);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_sb: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised successor to the instruction register: a DEPTH-entry instruction queue with field decode at the head.
- Sits between instruction memory and control/register file in the multicycle MIPS datapath, so fetch can run ahead of execute.
- Each entry stores the instruction word and its PC. A flush discards queued instructions on a taken branch or jump.

Parameters:
- DEPTH, 4, number of queued entries; power of two, minimum 2.
- PC_W, 32, width of stored PC tag.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the falling edge, matching datapath register timing.
- rst  in  1  asynchronous reset, active-high.
- push  in  1  write request (IRWr equivalent).
- instr_in  in  32  instruction word from memory.
- pc_in  in  PC_W  PC of instr_in.
- pop  in  1  consume head entry.
- flush  in  1  discard all entries.
- full  out  1  count == DEPTH.
- valid  out  1  count != 0; decode outputs are meaningful.
- count  out  CNT_W  occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was dropped.
- opcode  out  6  head[31:26].
- rs  out  5  head[25:21].
- rt  out  5  head[20:16].
- rd  out  5  head[15:11].
- shamt  out  5  head[10:6].
- funct  out  6  head[5:0].
- imm  out  16  head[15:0].
- imm_sext  out  32  head[15:0] sign-extended.
- IMM  out  26  head[25:0] (jump target).
- pc_out  out  PC_W  PC tag of head.

Behaviour:
- Reset (async, any time, including mid-operation):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = 0.
  - Storage contents are don't-care; all decode outputs and pc_out read 0 because valid = 0.
- Decode outputs are combinational from the head entry and are forced to 0 when valid = 0.
- Field slicing is exact as listed. rt is bits [20:16], width 5; no overlap with rs.
- Push accepted at a negedge when push=1, flush=0, and (full=0 or a pop is accepted at the same edge).
  - Writes {instr_in, pc_in} at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- Pop accepted at a negedge when pop=1, flush=0, and valid=1; rd_ptr increments modulo DEPTH.
- Count update: +1 for push only, -1 for pop only, unchanged for both or neither.
- Empty with push and pop at the same edge: no bypass. The pop is ignored and the push is accepted; count becomes 1, valid rises after the edge.
- Full with push and pop at the same edge: both accepted, count stays DEPTH, the new entry lands in the freed slot.
- Full with push and no pop: the push is dropped, storage is unchanged, and overflow is set (sticky until rst or flush).
- Empty with pop: ignored, no state change, no error flag.
- Flush has priority over push and pop at the same edge. It sets wr_ptr = rd_ptr = 0, count = 0, overflow = 0, and discards any same-edge push.
- Latency: an instruction pushed at edge N is visible on the decode outputs after edge N if the queue was empty; otherwise it appears after the entries ahead of it are popped.
- Outputs change only on falling edges or on rst assertion; there are no combinational paths from push/pop to full/valid/count.

Test Plan:
- Reset, then push 0x8C220004 @ pc 0x100 -> after edge: valid=1, count=1, opcode=0x23, rs=1, rt=2, imm=0x0004, imm_sext=0x00000004, pc_out=0x100.
- Push 0x2041FFFF -> rt=1, imm_sext=0xFFFFFFFF. Push 0x0810_0040 -> IMM=0x0100040. Push an R-type word 0x00430820 -> rd=1, funct=0x20, shamt=0.
- Push DEPTH words (pc 0,4,8,12) -> full=1, count=4. Push again with no pop -> dropped, overflow=1. Pop four times -> pc_out sequence 0,4,8,12, then valid=0 and all decode outputs 0.
- Fill to full, then push+pop for 6 consecutive edges -> count stays 4, pointers wrap, pops return the pc sequence in strict FIFO order.
- With count=3, assert flush together with push -> count=0, valid=0, overflow cleared, pushed word not stored.
- With the queue empty, assert pop+push together -> count=1, head equals the pushed word. Assert rst between edges with count=2 -> count=0 and valid=0 immediately, without waiting for a clock edge.
